alu_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 16-bit ALU. Accepts one operation request at a time over a valid/ready handshake, holds operands and opcode stable on the ALU inputs, pulses `alu_bgn` for the multi-cycle divide/multiply units, and waits for `alu_fin` or a fixed settle delay. It then captures the ALU's registered 32-bit result and flags, and returns them over a second valid/ready handshake. Illegal opcodes, divide-by-zero and hung multi-cycle operations are reported as errors without stalling the pipe.

---
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command front-end for the 16-bit ALU.
// Issues one op at a time, waits for fin or settle, returns result.
module alu_sequencer #(
    parameter int ALU_REG_LAT = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_sh,
    input  logic [3:0]  req_pos,
    output logic [3:0]  alu_control,
    output logic [15:0] alu_nr1,
    output logic [15:0] alu_nr2,
    output logic        alu_sh,
    output logic [3:0]  alu_pos,
    output logic        alu_bgn,
    input  logic        alu_fin,
    input  logic [31:0] alu_outbus,
    input  logic        alu_carry,
    input  logic        alu_borrow,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_flags,
    output logic        resp_err
);

    localparam int CMAX = (TIMEOUT > ALU_REG_LAT) ? TIMEOUT : ALU_REG_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_FIN,
        SETTLE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          multi;
    logic          req_bad;
    logic          accept;
    logic          timed_out;
    logic          settle_done;

    // divide/multiply need the start pulse and a fin wait
    assign multi       = (alu_control == 4'd0) || (alu_control == 4'd1);
    assign req_bad     = (req_op > 4'd6) ||
                         ((req_op == 4'd0) && (req_b == 16'd0));
    assign accept      = (state == IDLE) && req_valid;
    assign timed_out   = (cnt == CW'(TIMEOUT));
    assign settle_done = (cnt == CW'(ALU_REG_LAT));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_bgn    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_bad ? RESP : ISSUE;
            end
            ISSUE: begin
                alu_bgn   = multi;
                state_nxt = multi ? WAIT_FIN : SETTLE;
            end
            WAIT_FIN: begin
                if (alu_fin)        state_nxt = SETTLE;
                else if (timed_out) state_nxt = RESP;
            end
            SETTLE: begin
                if (settle_done) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // per-state cycle counter, 1 on the first cycle of each state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= CW'(1);
        end else if (state == WAIT_FIN || state == SETTLE) begin
            cnt <= cnt + CW'(1);
        end
    end

    // request capture; these registers drive the ALU directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control <= '0;
            alu_nr1     <= '0;
            alu_nr2     <= '0;
            alu_sh      <= 1'b0;
            alu_pos     <= '0;
        end else if (accept) begin
            alu_control <= req_op;
            alu_nr1     <= req_a;
            alu_nr2     <= req_b;
            alu_sh      <= req_sh;
            alu_pos     <= req_pos;
        end
    end

    // response capture: error paths zero the payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data  <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b0;
        end else if ((accept && req_bad) ||
                     (state == WAIT_FIN && !alu_fin && timed_out)) begin
            resp_data  <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b1;
        end else if (state == SETTLE && settle_done) begin
            resp_data  <= alu_outbus;
            resp_flags <= {alu_borrow, alu_carry};
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with a queue scoreboard.
// A behavioural ALU model answers the sequencer's issued operations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_sh;
    logic [3:0]  req_pos;
    logic [3:0]  alu_control;
    logic [15:0] alu_nr1;
    logic [15:0] alu_nr2;
    logic        alu_sh;
    logic [3:0]  alu_pos;
    logic        alu_bgn;
    logic        alu_fin;
    logic [31:0] alu_outbus;
    logic        alu_carry;
    logic        alu_borrow;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_flags;
    logic        resp_err;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sh      (req_sh),
        .req_pos     (req_pos),
        .alu_control (alu_control),
        .alu_nr1     (alu_nr1),
        .alu_nr2     (alu_nr2),
        .alu_sh      (alu_sh),
        .alu_pos     (alu_pos),
        .alu_bgn     (alu_bgn),
        .alu_fin     (alu_fin),
        .alu_outbus  (alu_outbus),
        .alu_carry   (alu_carry),
        .alu_borrow  (alu_borrow),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_flags  (resp_flags),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  f;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   bgn_cnt = 0;
    int   fin_delay = 18;
    int   fcnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ALU model: combinational datapath, fin after fin_delay cycles
    logic [15:0] a_eff;
    logic [16:0] sum;
    logic signed [31:0] prod;
    always_comb begin
        a_eff      = alu_sh ? (alu_nr1 << alu_pos) : alu_nr1;
        sum        = {1'b0, a_eff} + {1'b0, alu_nr2};
        prod       = $signed(a_eff) * $signed(alu_nr2);
        alu_outbus = '0;
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        case (alu_control)
            4'd0: if (alu_nr2 != 0)
                      alu_outbus = {a_eff % alu_nr2, a_eff / alu_nr2};
            4'd1: alu_outbus = prod;
            4'd2: begin
                alu_outbus = {16'd0, a_eff - alu_nr2};
                alu_borrow = a_eff < alu_nr2;
            end
            4'd3: begin
                alu_outbus = {16'd0, sum[15:0]};
                alu_carry  = sum[16];
            end
            4'd4: alu_outbus = {16'd0, a_eff | alu_nr2};
            4'd5: alu_outbus = {16'd0, a_eff & alu_nr2};
            4'd6: alu_outbus = {16'd0, a_eff ^ alu_nr2};
            default: alu_outbus = '0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst)          fcnt <= 0;
        else if (alu_bgn) fcnt <= fin_delay;
        else if (fcnt > 0) fcnt <= fcnt - 1;
    end
    assign alu_fin = (fcnt == 1);

    // monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (!rst && alu_bgn) bgn_cnt++;
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected resp: got %h want none", resp_data);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("resp_data", resp_data, x.d);
                chk("resp_flags", 32'(resp_flags), 32'(x.f));
                chk("resp_err", 32'(resp_err), 32'(x.e));
            end
        end
    end

    task automatic run(input string nm, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic sh, input logic [3:0] pos,
                       input logic [31:0] ed, input logic [1:0] ef,
                       input logic ee, input int elat, input int ebgn,
                       input int hold);
        int lat;
        int b0;
        int w;
        exp_t x;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        x.d = ed; x.f = ef; x.e = ee;
        sb.push_back(x);
        resp_ready = (hold == 0);
        b0 = bgn_cnt;
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b; req_sh = sh; req_pos = pos;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " alu_control held"}, 32'(alu_control), 32'(op));
        chk({nm, " alu_nr1 held"}, 32'(alu_nr1), 32'(a));
        if (hold > 0) begin
            req_valid = 1'b1;
            req_op = 4'd3; req_a = 16'd1; req_b = 16'd1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({nm, " held data"}, resp_data, ed);
                chk({nm, " held valid"}, 32'(resp_valid), 32'd1);
                chk({nm, " req_ready low"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
        end
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({nm, " back idle"}, 32'(req_ready), 32'd1);
        chk({nm, " bgn pulses"}, 32'(bgn_cnt - b0), 32'(ebgn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_sh = 1'b0; req_pos = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst alu_bgn", 32'(alu_bgn), 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst alu_control", 32'(alu_control), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("add", 4'd3, 16'hFFFF, 16'h0001, 1'b0, 4'd0,
            32'h0000_0000, 2'b01, 1'b0, 4, 0, 0);
        run("sub", 4'd2, 16'h0005, 16'h0007, 1'b0, 4'd0,
            32'h0000_FFFE, 2'b10, 1'b0, 4, 0, 0);
        run("or_shift", 4'd4, 16'h0003, 16'h0100, 1'b1, 4'd4,
            32'h0000_0130, 2'b00, 1'b0, 4, 0, 0);
        run("xor", 4'd6, 16'hAAAA, 16'hFFFF, 1'b0, 4'd0,
            32'h0000_5555, 2'b00, 1'b0, 4, 0, 0);
        fin_delay = 18;
        run("mul", 4'd1, 16'h0003, 16'hFFFE, 1'b0, 4'd0,
            32'hFFFF_FFFA, 2'b00, 1'b0, 22, 1, 0);
        fin_delay = 5;
        run("div", 4'd0, 16'd100, 16'd7, 1'b0, 4'd0,
            32'h0002_000E, 2'b00, 1'b0, 9, 1, 0);
        run("illegal", 4'd9, 16'h1234, 16'h5678, 1'b0, 4'd0,
            32'h0, 2'b00, 1'b1, 1, 0, 0);
        run("div0", 4'd0, 16'h0010, 16'h0000, 1'b0, 4'd0,
            32'h0, 2'b00, 1'b1, 1, 0, 0);
        fin_delay = 0;
        run("timeout", 4'd0, 16'd10, 16'd3, 1'b0, 4'd0,
            32'h0, 2'b00, 1'b1, 66, 1, 0);
        run("and_bp", 4'd5, 16'hF0F0, 16'h3C3C, 1'b0, 4'd0,
            32'h0000_3030, 2'b00, 1'b0, 4, 0, 10);

        // reset during WAIT_FIN of a hung divide; nothing is expected back
        req_valid = 1'b1;
        req_op = 4'd0; req_a = 16'd50; req_b = 16'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst alu_bgn", 32'(alu_bgn), 32'd0);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst alu_control", 32'(alu_control), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fin_delay = 18;
        @(posedge clk); #1;
        run("add_after_rst", 4'd3, 16'd2, 16'd3, 1'b0, 4'd0,
            32'h0000_0005, 2'b00, 1'b0, 4, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
